// File: rtl/ddr3_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_bridge_pkg
//   Shared types and constants for the canny-stage DDR3 access bridge.
//   bridge_state_t : bridge FSM states
//   BYTES_PER_WORD : bytes in one 128-bit client word (also byteenable width)
//   WORD_SHIFT     : log2(BYTES_PER_WORD), word index -> byte offset
//   DATA_W         : client / Avalon data width
// ---------------------------------------------------------------------------
package ddr3_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT
    } bridge_state_t;

    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_SHIFT     = 4;
    localparam int DATA_W         = 128;

endpackage

// File: rtl/ddr3_access_bridge.sv
// ---------------------------------------------------------------------------
// ddr3_access_bridge
//   Responder for a canny pipeline stage's single-word DDR3 requests. Each
//   rd_en / wr_en pulse becomes one Avalon-MM transaction toward the HPS
//   F2SDRAM port; a one-cycle completion pulse is returned to the client.
//   Only one request is outstanding; requests arriving while busy are dropped
//   and flagged.
//
// Ports
//   clock, reset        : system clock, asynchronous active-high reset
//   sdram_address       : 128-bit word index from the client
//   rd_en / wr_en       : one-cycle request pulses
//   write_data_input    : write word, sampled with wr_en
//   read_data           : last read word, held until the next read completes
//   write_complete      : pulse, cycle after the Avalon write is accepted
//   read_complete       : pulse, cycle after read data (or a timeout)
//   avm_*               : Avalon-MM master toward the SDRAM port
//   req_overrun         : sticky, some request was dropped
//   rd_timeout          : sticky, some read never returned data
// ---------------------------------------------------------------------------
module ddr3_access_bridge
    import ddr3_bridge_pkg::*;
#(
    parameter int                    AVM_ADDR_W     = 32,
    parameter logic [AVM_ADDR_W-1:0] BASE_ADDR      = 32'h3000_0000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               sdram_address,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         write_data_input,
    output logic [DATA_W-1:0]         read_data,
    output logic                      write_complete,
    output logic                      read_complete,
    output logic [AVM_ADDR_W-1:0]     avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATA_W-1:0]         avm_writedata,
    output logic [BYTES_PER_WORD-1:0] avm_byteenable,
    output logic                      avm_burstcount,
    input  logic                      avm_waitrequest,
    input  logic [DATA_W-1:0]         avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic                      req_overrun,
    output logic                      rd_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Word index to byte address, all arithmetic in AVM_ADDR_W bits so the
    // shift drops the top index bits and the base addition wraps.
    function automatic logic [AVM_ADDR_W-1:0] word_to_byte(input logic [31:0] word);
        logic [AVM_ADDR_W-1:0] w;
        w = AVM_ADDR_W'(word);
        return BASE_ADDR + (w << WORD_SHIFT);
    endfunction

    bridge_state_t           state, state_d;
    logic [CNT_W-1:0]        tmo_cnt, tmo_cnt_d, tmo_cnt_inc;
    logic [AVM_ADDR_W-1:0]   avm_address_d;
    logic [DATA_W-1:0]       avm_writedata_d;
    logic [DATA_W-1:0]       read_data_d;
    logic                    avm_read_d, avm_write_d;
    logic                    write_complete_d, read_complete_d;
    logic                    req_overrun_d, rd_timeout_d;

    assign avm_byteenable = '1;
    assign avm_burstcount = 1'b1;
    assign tmo_cnt_inc    = tmo_cnt + CNT_W'(1);

    // Next-state and next-register values; every output is registered so
    // the Avalon side sees glitch-free, stable strobes and address/data.
    always_comb begin
        state_d          = state;
        tmo_cnt_d        = tmo_cnt;
        avm_address_d    = avm_address;
        avm_writedata_d  = avm_writedata;
        read_data_d      = read_data;
        avm_read_d       = avm_read;
        avm_write_d      = avm_write;
        write_complete_d = 1'b0;
        read_complete_d  = 1'b0;
        req_overrun_d    = req_overrun;
        rd_timeout_d     = rd_timeout;

        case (state)
            IDLE: begin
                if (wr_en) begin
                    // A simultaneous read loses to the write.
                    avm_address_d   = word_to_byte(sdram_address);
                    avm_writedata_d = write_data_input;
                    avm_write_d     = 1'b1;
                    state_d         = WR_ISSUE;
                    if (rd_en) begin
                        req_overrun_d = 1'b1;
                    end
                end else if (rd_en) begin
                    avm_address_d = word_to_byte(sdram_address);
                    avm_read_d    = 1'b1;
                    state_d       = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (!avm_waitrequest) begin
                    avm_write_d      = 1'b0;
                    write_complete_d = 1'b1;
                    state_d          = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    read_data_d     = avm_readdata;
                    read_complete_d = 1'b1;
                    state_d         = IDLE;
                end else if (tmo_cnt_inc == CNT_LAST) begin
                    // Counter lands on TIMEOUT_CYCLES-1 together with the
                    // forced completion, TIMEOUT_CYCLES cycles after accept.
                    tmo_cnt_d       = tmo_cnt_inc;
                    read_data_d     = '0;
                    read_complete_d = 1'b1;
                    rd_timeout_d    = 1'b1;
                    state_d         = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state != IDLE) && (rd_en || wr_en)) begin
            req_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            read_data      <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            write_complete <= 1'b0;
            read_complete  <= 1'b0;
            req_overrun    <= 1'b0;
            rd_timeout     <= 1'b0;
        end else begin
            state          <= state_d;
            tmo_cnt        <= tmo_cnt_d;
            avm_address    <= avm_address_d;
            avm_writedata  <= avm_writedata_d;
            read_data      <= read_data_d;
            avm_read       <= avm_read_d;
            avm_write      <= avm_write_d;
            write_complete <= write_complete_d;
            read_complete  <= read_complete_d;
            req_overrun    <= req_overrun_d;
            rd_timeout     <= rd_timeout_d;
        end
    end

endmodule
